// File: rtl/alu_mc_if.sv
// alu_mc request/result bundle.
// Operands in through valid/ready, result and condition codes out.
interface alu_mc_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       aluFun;
  logic             setCC;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] valE;
  logic             ZF;
  logic             SF;
  logic             OF;

  modport master (
    output in_valid, aluFun, setCC, aluA, aluB, out_ready,
    input  in_ready, out_valid, valE, ZF, SF, OF
  );

  modport slave (
    input  in_valid, aluFun, setCC, aluA, aluB, out_ready,
    output in_ready, out_valid, valE, ZF, SF, OF
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle Y86-64 execute ALU: single-cycle logic/arith/shift ops,
// iterative shift-add multiply, registered ZF/SF/OF.
module alu_mc #(
  parameter int WIDTH = 64
) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_XOR = 3'b011;
  localparam logic [2:0] F_MUL = 3'b100;
  localparam logic [2:0] F_SHL = 3'b101;
  localparam logic [2:0] F_SHR = 3'b110;
  localparam logic [2:0] F_SAR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_vale;
  logic             r_zf;
  logic             r_sf;
  logic             r_of;
  logic             r_setcc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [SHW:0]     r_cnt;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_of;
  logic [WIDTH-1:0] w_step;
  logic             w_am;
  logic             w_bm;
  logic             w_rm;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.valE      = r_vale;
  assign bus.ZF        = r_zf;
  assign bus.SF        = r_sf;
  assign bus.OF        = r_of;

  assign w_sh   = bus.aluA[SHW-1:0];
  assign w_step = r_acc + (r_a[0] ? r_b : '0);
  assign w_am   = bus.aluA[WIDTH-1];
  assign w_bm   = bus.aluB[WIDTH-1];
  assign w_rm   = w_res[WIDTH-1];

  // Single-cycle result and overflow from the live request operands.
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    unique case (bus.aluFun)
      F_ADD: begin
        w_res = bus.aluB + bus.aluA;
        w_of  = (w_am == w_bm) && (w_rm != w_am);
      end
      F_SUB: begin
        w_res = bus.aluB - bus.aluA;
        w_of  = (w_am != w_bm) && (w_rm != w_bm);
      end
      F_AND: w_res = bus.aluB & bus.aluA;
      F_XOR: w_res = bus.aluB ^ bus.aluA;
      F_MUL: w_res = '0;
      F_SHL: w_res = bus.aluB << w_sh;
      F_SHR: w_res = bus.aluB >> w_sh;
      F_SAR: w_res = $unsigned($signed(bus.aluB) >>> w_sh);
      default: w_res = '0;
    endcase
  end

  // Control FSM, multiply datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_vale      <= '0;
      r_zf        <= 1'b1;
      r_sf        <= 1'b0;
      r_of        <= 1'b0;
      r_setcc     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_setcc    <= bus.setCC;
            r_a        <= bus.aluA;
            r_b        <= bus.aluB;
            r_in_ready <= 1'b0;
            if (bus.aluFun == F_MUL) begin
              r_acc   <= '0;
              r_cnt   <= (SHW+1)'(WIDTH);
              r_state <= S_MUL;
            end else begin
              r_vale      <= w_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
              if (bus.setCC) begin
                r_zf <= (w_res == '0);
                r_sf <= w_rm;
                r_of <= w_of;
              end
            end
          end
        end
        S_MUL: begin
          r_acc <= w_step;
          r_b   <= r_b << 1;
          r_a   <= r_a >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == (SHW+1)'(1)) begin
            r_vale      <= w_step;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
            if (r_setcc) begin
              r_zf <= (w_step == '0);
              r_sf <= w_step[WIDTH-1];
              r_of <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule
